// File: rtl/packet_assembler_ecc.sv
// Data island packet assembler: captures one header plus four subpackets, then serialises
// them over 32 pixel clocks with 8-bit BCH parity appended to each stream.
module packet_assembler_ecc #(
    parameter logic [7:0] ECC_POLY = 8'h83
) (
    input  logic             clk_pixel,
    input  logic             reset,
    input  logic             data_island_period,
    input  logic [23:0]      header,
    input  logic [3:0][55:0] sub,
    output logic [4:0]       counter,
    output logic             packet_enable,
    output logic [8:0]       packet_data,
    output logic             packet_done
);

    logic [4:0]       counter_q, counter_d;
    logic [23:0]      header_q;
    logic [3:0][55:0] sub_q;
    logic [7:0]       hecc_q, hecc_d;
    logic [3:0][7:0]  secc_q, secc_d;
    logic [8:0]       packet_data_q, packet_data_d;
    logic             packet_done_q, packet_done_d;
    logic             first;
    logic [23:0]      hdr_cur;
    logic             hbit;
    logic [7:0]       lane_bits;

    function automatic logic [7:0] ecc_step(input logic [7:0] e, input logic b);
        ecc_step = (e >> 1) ^ ((e[0] ^ b) ? ECC_POLY : 8'h00);
    endfunction

    // Pixel 0 works from the live inputs; the shadows cover pixels 1..31.
    assign first   = (counter_q == 5'd0);
    assign hdr_cur = first ? header : header_q;

    always_comb begin
        hbit   = hecc_q[counter_q[2:0]];
        hecc_d = hecc_q;
        if (counter_q < 5'd24) begin
            hbit   = hdr_cur[counter_q];
            hecc_d = ecc_step(first ? 8'h00 : hecc_q, hdr_cur[counter_q]);
        end
        if (!data_island_period) begin
            hecc_d = 8'h00;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sub
            logic [55:0] s_cur;
            logic [7:0]  base, mid, nxt;
            logic        b0, b1;

            always_comb begin
                s_cur = first ? sub[gi] : sub_q[gi];
                base  = first ? 8'h00 : secc_q[gi];
                mid   = base;
                nxt   = secc_q[gi];
                b0    = secc_q[gi][{counter_q[1:0], 1'b0}];
                b1    = secc_q[gi][{counter_q[1:0], 1'b1}];
                if (counter_q < 5'd28) begin
                    b0  = s_cur[{counter_q, 1'b0}];
                    b1  = s_cur[{counter_q, 1'b1}];
                    mid = ecc_step(base, b0);
                    nxt = ecc_step(mid, b1);
                end
                if (!data_island_period) begin
                    nxt = 8'h00;
                end
            end

            assign secc_d[gi]           = nxt;
            assign lane_bits[2*gi +: 2] = {b1, b0};
        end
    endgenerate

    always_comb begin
        counter_d     = data_island_period ? counter_q + 5'd1 : 5'd0;
        packet_data_d = data_island_period ? {lane_bits, hbit} : 9'h000;
        packet_done_d = data_island_period && (counter_q == 5'd31);
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            counter_q     <= 5'd0;
            header_q      <= '0;
            sub_q         <= '0;
            hecc_q        <= 8'h00;
            secc_q        <= '0;
            packet_data_q <= 9'h000;
            packet_done_q <= 1'b0;
        end else begin
            counter_q     <= counter_d;
            hecc_q        <= hecc_d;
            secc_q        <= secc_d;
            packet_data_q <= packet_data_d;
            packet_done_q <= packet_done_d;
            if (data_island_period && first) begin
                header_q <= header;
                sub_q    <= sub;
            end
        end
    end

    assign counter       = counter_q;
    assign packet_enable = data_island_period && (counter_q == 5'd31);
    assign packet_data   = packet_data_q;
    assign packet_done   = packet_done_q;

endmodule

// File: tb/tb_packet_assembler_ecc.sv
// Scoreboard bench for packet_assembler_ecc: a packet-level reference model predicts every
// registered output word, and a negedge monitor pops and compares them.
module tb_packet_assembler_ecc;

    logic             clk_pixel = 1'b0;
    logic             reset;
    logic             data_island_period;
    logic [23:0]      header;
    logic [3:0][55:0] sub;
    logic [4:0]       counter;
    logic             packet_enable;
    logic [8:0]       packet_data;
    logic             packet_done;

    packet_assembler_ecc dut (
        .clk_pixel          (clk_pixel),
        .reset              (reset),
        .data_island_period (data_island_period),
        .header             (header),
        .sub                (sub),
        .counter            (counter),
        .packet_enable      (packet_enable),
        .packet_data        (packet_data),
        .packet_done        (packet_done)
    );

    always #5 clk_pixel = ~clk_pixel;

    typedef struct {
        logic [8:0] pd;
        logic       done;
        logic [4:0] cnt;
    } exp_t;

    exp_t       sb_q[$];
    int         checks = 0;
    int         errors = 0;
    int         m_cnt  = 0;
    logic [8:0] m_words [32];
    logic [31:0] cap = '0;
    int         done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // BCH parity over the first n bits of a stream, LSB first, generator 1+x^6+x^7+x^8.
    function automatic logic [7:0] bch(input logic [63:0] bits, input int n);
        logic [7:0] r = 8'h00;
        logic       fb;
        for (int i = 0; i < n; i++) begin
            fb = r[0] ^ bits[i];
            r  = r >> 1;
            if (fb) r = r ^ 8'h83;
        end
        return r;
    endfunction

    // Whole packet as 32 output words: header stream is {parity, header}, each
    // subpacket stream is {parity, subpacket}, two subpacket bits per pixel.
    task automatic build_packet(input logic [23:0] h, input logic [3:0][55:0] s);
        logic [31:0] hs;
        logic [63:0] ss;
        hs = {bch(64'(h), 24), h};
        for (int c = 0; c < 32; c++) m_words[c] = 9'h000;
        for (int c = 0; c < 32; c++) m_words[c][0] = hs[c];
        for (int k = 0; k < 4; k++) begin
            ss = {bch(64'(s[k]), 56), s[k]};
            for (int c = 0; c < 32; c++) begin
                m_words[c][2*k+1] = ss[2*c];
                m_words[c][2*k+2] = ss[2*c+1];
            end
        end
    endtask

    // One pixel: drive inputs, check live outputs, then predict the registered result.
    task automatic do_cycle(input logic d, input logic [23:0] h, input logic [3:0][55:0] s);
        exp_t e;
        data_island_period = d;
        header             = h;
        sub                = s;
        #1;
        chk("counter", 32'(counter), 32'(m_cnt));
        chk("packet_enable", 32'(packet_enable), 32'(d && (m_cnt == 31)));
        @(posedge clk_pixel);
        if (d) begin
            if (m_cnt == 0) build_packet(h, s);
            e.pd   = m_words[m_cnt];
            e.done = (m_cnt == 31);
            m_cnt  = (m_cnt + 1) % 32;
        end else begin
            e.pd   = 9'h000;
            e.done = 1'b0;
            m_cnt  = 0;
        end
        e.cnt = 5'(m_cnt);
        sb_q.push_back(e);
        #1;
    endtask

    function automatic logic [3:0][55:0] rand_sub();
        logic [3:0][55:0] s;
        for (int k = 0; k < 4; k++) s[k] = 56'({$urandom(), $urandom()});
        return s;
    endfunction

    task automatic run_packet(input logic [23:0] h, input logic [3:0][55:0] s, input bit junk);
        for (int c = 0; c < 32; c++) begin
            if (junk && c != 0) do_cycle(1'b1, 24'($urandom()), rand_sub());
            else                do_cycle(1'b1, h, s);
        end
    endtask

    // Monitor: one scoreboard entry per clock edge, plus a record of the header lane.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_pixel);
            cap = {packet_data[0], cap[31:1]};
            if (packet_done) done_cnt++;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("packet_data", 32'(packet_data), 32'(e.pd));
                chk("packet_done", 32'(packet_done), 32'(e.done));
                chk("counter_next", 32'(counter), 32'(e.cnt));
            end
        end
    end

    initial begin
        logic [3:0][55:0] zs;
        logic [3:0][55:0] s2;
        logic [23:0]      h2;
        int               d0;
        zs = '0;
        reset = 1'b1;
        data_island_period = 1'b0;
        header = '0;
        sub = '0;
        #2;
        chk("reset_counter", 32'(counter), 32'd0);
        chk("reset_packet_data", 32'(packet_data), 32'h0);
        chk("reset_done", 32'(packet_done), 32'd0);
        @(posedge clk_pixel);
        #1 reset = 1'b0;
        do_cycle(1'b0, '0, zs);

        // Asynchronous reset partway through a packet.
        for (int c = 0; c < 6; c++) do_cycle(1'b1, 24'hABCDEF, rand_sub());
        #6 reset = 1'b1;
        #1;
        chk("async_counter", 32'(counter), 32'd0);
        chk("async_packet_data", 32'(packet_data), 32'h0);
        chk("async_enable", 32'(packet_enable), 32'd0);
        chk("async_done", 32'(packet_done), 32'd0);
        @(posedge clk_pixel);
        @(posedge clk_pixel);
        #1 reset = 1'b0;
        m_cnt = 0;
        do_cycle(1'b0, '0, zs);

        // All-zero packet.
        d0 = done_cnt;
        run_packet(24'h0, zs, 1'b0);
        do_cycle(1'b0, '0, zs);
        chk("zero_pkt_done_pulses", 32'(done_cnt - d0), 32'd1);

        // Single header bit: parity 8'h4A.
        run_packet(24'h000001, zs, 1'b0);
        @(negedge clk_pixel);
        #1;
        chk("hdr1_lane", cap, {8'h4A, 24'h000001});
        do_cycle(1'b0, '0, zs);

        // Single bit in subpacket 2.
        s2 = zs;
        s2[2] = 56'h1;
        run_packet(24'h0, s2, 1'b0);
        do_cycle(1'b0, '0, zs);

        // Back-to-back packets, header changed at the counter 31 edge.
        h2 = 24'h5A0C33;
        run_packet(24'h000001, rand_sub(), 1'b0);
        run_packet(h2, rand_sub(), 1'b1);
        @(negedge clk_pixel);
        #1;
        chk("b2b_hdr_lane", cap, {bch(64'(h2), 24), h2});
        do_cycle(1'b0, '0, zs);

        // Drop mid-packet at counter 10, then restart.
        d0 = done_cnt;
        for (int c = 0; c < 10; c++) do_cycle(1'b1, 24'h000001, s2);
        do_cycle(1'b0, 24'h000001, s2);
        do_cycle(1'b0, '0, zs);
        chk("drop_no_done", 32'(done_cnt - d0), 32'd0);
        run_packet(24'h000001, zs, 1'b0);
        @(negedge clk_pixel);
        #1;
        chk("restart_hdr_lane", cap, {8'h4A, 24'h000001});

        // Randomised traffic with occasional aborted packets and idle gaps.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int c = 0; c < int'($urandom_range(1, 31)); c++)
                    do_cycle(1'b1, 24'($urandom()), rand_sub());
                for (int c = 0; c < int'($urandom_range(1, 3)); c++)
                    do_cycle(1'b0, 24'($urandom()), rand_sub());
            end
            run_packet(24'($urandom()), rand_sub(), 1'b1);
            if ($urandom_range(0, 2) == 0) do_cycle(1'b0, '0, zs);
        end
        do_cycle(1'b0, '0, zs);
        do_cycle(1'b0, '0, zs);
        @(negedge clk_pixel);
        #1;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
